isp_mosaic: RTL and testbench

ISP_MOSAIC -- requirements
Module: isp_mosaic

---
 rtl/isp_pkg.sv | 20 ++
 rtl/isp_frame_cnt.sv | 72 +++++++
 rtl/isp_mosaic.sv | 164 ++++++++++++++++
 tb/tb_isp_mosaic.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared ISP definitions: Bayer phase codes, frame FSM encoding and phase helper.
// Pure declarations; no latency and no flow control.
package isp_pkg;

    localparam logic [1:0] PH_R  = 2'b00;
    localparam logic [1:0] PH_GR = 2'b01;
    localparam logic [1:0] PH_GB = 2'b10;
    localparam logic [1:0] PH_B  = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } frame_st_t;

    function automatic logic [1:0] bayer_phase(input logic row_lsb, input logic col_lsb,
                                               input logic [1:0] pattern);
        return {row_lsb, col_lsb} ^ pattern;
    endfunction

endpackage

// File: rtl/isp_frame_cnt.sv
// Frame tracker: accepts pixels, keeps col/row position and decodes sof/eol/eof/error for the current pixel.
// Decode is combinational off registered state (0 cycles); no backpressure, every valid pixel is judged the cycle it arrives.
module isp_frame_cnt
    import isp_pkg::*;
#(
    parameter int WIDTH  = 1920,
    parameter int HEIGHT = 1080
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic i_vld,
    input  logic i_sof,
    output logic o_acc,
    output logic o_col_lsb,
    output logic o_row_lsb,
    output logic o_sof,
    output logic o_eol,
    output logic o_eof,
    output logic o_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGHT + 1);

    frame_st_t     r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_acc;
    logic          w_eol;
    logic          w_eof;

    // A start-of-frame always re-anchors the current pixel at (0,0).
    assign w_acc = i_vld && (r_state == ST_ACTIVE || i_sof);
    assign w_col = i_sof ? '0 : r_col;
    assign w_row = i_sof ? '0 : r_row;
    assign w_eol = (w_col == CW'(WIDTH - 1));
    assign w_eof = w_eol && (w_row == RW'(HEIGHT - 1));

    assign o_acc     = w_acc;
    assign o_col_lsb = w_col[0];
    assign o_row_lsb = w_row[0];
    assign o_sof     = w_acc && i_sof;
    assign o_eol     = w_acc && w_eol;
    assign o_eof     = w_acc && w_eof;
    assign o_err     = i_vld && i_sof && (r_state == ST_ACTIVE) && (r_col != '0 || r_row != '0);

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else if (w_acc) begin
            if (w_eof) begin
                r_state <= ST_IDLE;
                r_col   <= '0;
                r_row   <= '0;
            end else begin
                r_state <= ST_ACTIVE;
                if (w_eol) begin
                    r_col <= '0;
                    r_row <= w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
            end
        end
    end

endmodule

// File: rtl/isp_mosaic.sv
// RGB-to-Bayer remosaic: 2-cycle latency, no backpressure (one sample out per accepted pixel, in order).
// Optional per-frame R/G/B sample totals when ISP_MOSAIC_STATS_EN is defined.
module isp_mosaic
    import isp_pkg::*;
#(
    parameter int         BITS    = 8,
    parameter int         WIDTH   = 1920,
    parameter int         HEIGHT  = 1080,
    parameter logic [1:0] PATTERN = 2'b00
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [3*BITS-1:0] in_rgb,
    output logic              out_valid,
    output logic [BITS-1:0]   out_raw,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              frame_err
`ifdef ISP_MOSAIC_STATS_EN
    ,
    output logic              stat_valid,
    output logic [31:0]       stat_r,
    output logic [31:0]       stat_g,
    output logic [31:0]       stat_b
`endif
);

    logic              w_acc;
    logic              w_col_lsb;
    logic              w_row_lsb;
    logic              w_sof;
    logic              w_eol;
    logic              w_eof;
    logic              w_err;
    logic              r_s1_vld;
    logic [3*BITS-1:0] r_s1_rgb;
    logic [1:0]        r_s1_ph;
    logic              r_s1_sof;
    logic              r_s1_eol;
    logic              r_s1_eof;
    logic              r_s1_err;
    logic [BITS-1:0]   w_sel;

    isp_frame_cnt #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_frame_cnt (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .i_vld     (in_valid),
        .i_sof     (in_sof),
        .o_acc     (w_acc),
        .o_col_lsb (w_col_lsb),
        .o_row_lsb (w_row_lsb),
        .o_sof     (w_sof),
        .o_eol     (w_eol),
        .o_eof     (w_eof),
        .o_err     (w_err)
    );

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_rgb <= '0;
            r_s1_ph  <= PH_R;
            r_s1_sof <= 1'b0;
            r_s1_eol <= 1'b0;
            r_s1_eof <= 1'b0;
            r_s1_err <= 1'b0;
        end else begin
            r_s1_vld <= w_acc;
            r_s1_rgb <= in_rgb;
            r_s1_ph  <= bayer_phase(w_row_lsb, w_col_lsb, PATTERN);
            r_s1_sof <= w_sof;
            r_s1_eol <= w_eol;
            r_s1_eof <= w_eof;
            r_s1_err <= w_err;
        end
    end

    always_comb begin
        w_sel = r_s1_rgb[2*BITS-1:BITS];
        case (r_s1_ph)
            PH_R:    w_sel = r_s1_rgb[3*BITS-1:2*BITS];
            PH_B:    w_sel = r_s1_rgb[BITS-1:0];
            default: w_sel = r_s1_rgb[2*BITS-1:BITS];
        endcase
    end

    // Everything leaving the block is forced to zero on idle cycles.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_raw   <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= r_s1_vld;
            out_raw   <= r_s1_vld ? w_sel : '0;
            out_sof   <= r_s1_vld && r_s1_sof;
            out_eol   <= r_s1_vld && r_s1_eol;
            out_eof   <= r_s1_vld && r_s1_eof;
            frame_err <= r_s1_vld && r_s1_err;
        end
    end

`ifdef ISP_MOSAIC_STATS_EN
    logic [1:0]  r_out_ph;
    logic [31:0] r_acc_r;
    logic [31:0] r_acc_g;
    logic [31:0] r_acc_b;
    logic [31:0] w_samp;
    logic [31:0] w_nxt_r;
    logic [31:0] w_nxt_g;
    logic [31:0] w_nxt_b;

    always_ff @(posedge pclk) begin
        if (!rst_n) r_out_ph <= PH_R;
        else        r_out_ph <= r_s1_ph;
    end

    // A restart pixel begins a fresh total that already includes its own sample.
    assign w_samp  = 32'(out_raw);
    assign w_nxt_r = (frame_err ? 32'd0 : r_acc_r) + ((r_out_ph == PH_R) ? w_samp : 32'd0);
    assign w_nxt_g = (frame_err ? 32'd0 : r_acc_g) +
                     ((r_out_ph == PH_GR || r_out_ph == PH_GB) ? w_samp : 32'd0);
    assign w_nxt_b = (frame_err ? 32'd0 : r_acc_b) + ((r_out_ph == PH_B) ? w_samp : 32'd0);

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_acc_r    <= '0;
            r_acc_g    <= '0;
            r_acc_b    <= '0;
            stat_valid <= 1'b0;
            stat_r     <= '0;
            stat_g     <= '0;
            stat_b     <= '0;
        end else begin
            stat_valid <= 1'b0;
            if (out_valid) begin
                if (out_eof) begin
                    stat_valid <= 1'b1;
                    stat_r     <= w_nxt_r;
                    stat_g     <= w_nxt_g;
                    stat_b     <= w_nxt_b;
                    r_acc_r    <= '0;
                    r_acc_g    <= '0;
                    r_acc_b    <= '0;
                end else begin
                    r_acc_r <= w_nxt_r;
                    r_acc_g <= w_nxt_g;
                    r_acc_b <= w_nxt_b;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_isp_mosaic.sv
// Bench for isp_mosaic (WIDTH=4, HEIGHT=2): RGGB and BGGR instances driven in parallel, scoreboard per instance.
module tb_isp_mosaic;

    localparam int W = 4;
    localparam int H = 2;

    typedef struct {
        logic [7:0] raw;
        logic [3:0] fl;
        int         cyc;
    } exp_t;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    logic [23:0] in_rgb;
    logic        o_vld [2];
    logic [7:0]  o_raw [2];
    logic        o_sof [2];
    logic        o_eol [2];
    logic        o_eof [2];
    logic        o_err [2];
`ifdef ISP_MOSAIC_STATS_EN
    logic        s_vld [2];
    logic [31:0] s_r [2];
    logic [31:0] s_g [2];
    logic [31:0] s_b [2];
    int          st_cnt = 0;
`endif

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   st_win = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    isp_mosaic #(.BITS(8), .WIDTH(W), .HEIGHT(H), .PATTERN(2'b00)) u0 (
        .pclk(pclk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_rgb(in_rgb),
        .out_valid(o_vld[0]), .out_raw(o_raw[0]), .out_sof(o_sof[0]), .out_eol(o_eol[0]),
        .out_eof(o_eof[0]), .frame_err(o_err[0])
`ifdef ISP_MOSAIC_STATS_EN
        , .stat_valid(s_vld[0]), .stat_r(s_r[0]), .stat_g(s_g[0]), .stat_b(s_b[0])
`endif
    );

    isp_mosaic #(.BITS(8), .WIDTH(W), .HEIGHT(H), .PATTERN(2'b11)) u1 (
        .pclk(pclk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_rgb(in_rgb),
        .out_valid(o_vld[1]), .out_raw(o_raw[1]), .out_sof(o_sof[1]), .out_eol(o_eol[1]),
        .out_eof(o_eof[1]), .frame_err(o_err[1])
`ifdef ISP_MOSAIC_STATS_EN
        , .stat_valid(s_vld[1]), .stat_r(s_r[1]), .stat_g(s_g[1]), .stat_b(s_b[1])
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pick(input logic [23:0] rgb, input logic [1:0] ph);
        case (ph)
            2'b00:   return rgb[23:16];
            2'b11:   return rgb[7:0];
            default: return rgb[15:8];
        endcase
    endfunction

    task automatic cmp_out(input int k, input exp_t e);
        chk($sformatf("u%0d_raw", k), o_raw[k], e.raw);
        chk($sformatf("u%0d_flags", k), {o_sof[k], o_eol[k], o_eof[k], o_err[k]}, e.fl);
        chk($sformatf("u%0d_latency", k), cyc, e.cyc);
    endtask

    task automatic mon_one(input int k);
        exp_t e;
        if (o_vld[k]) begin
            if (k == 0 && q0.size() == 0 || k == 1 && q1.size() == 0)
                chk($sformatf("u%0d_unexpected_out", k), 1, 0);
            else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                cmp_out(k, e);
            end
        end else begin
            chk($sformatf("u%0d_idle_zero", k), {o_raw[k], o_sof[k], o_eol[k], o_eof[k], o_err[k]}, 0);
        end
`ifdef ISP_MOSAIC_STATS_EN
        if (st_win && s_vld[k]) begin
            st_cnt++;
            chk($sformatf("u%0d_stat_r", k), s_r[k], 2);
            chk($sformatf("u%0d_stat_g", k), s_g[k], 8);
            chk($sformatf("u%0d_stat_b", k), s_b[k], 6);
        end
`endif
    endtask

    always @(negedge pclk) begin
        if (mon_en) begin
            mon_one(0);
            mon_one(1);
        end
    end

    // Drive one pixel; when exp is set, push the expected sample for each instance.
    task automatic px(input logic [23:0] rgb, input logic sof, input logic exp,
                      input int col, input int row, input logic err,
                      input logic [7:0] r0, input logic [7:0] r1);
        exp_t e;
        @(negedge pclk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_rgb   = rgb;
        if (exp) begin
            e.fl  = {col == 0 && row == 0, col == W - 1, col == W - 1 && row == H - 1, err};
            e.cyc = cyc + 2;
            e.raw = r0;
            q0.push_back(e);
            e.raw = r1;
            q1.push_back(e);
        end
    endtask

    task automatic pxm(input logic [23:0] rgb, input logic sof, input logic exp,
                       input int col, input int row, input logic err);
        logic [1:0] pos;
        pos = {row[0], col[0]};
        px(rgb, sof, exp, col, row, err, pick(rgb, pos ^ 2'b00), pick(rgb, pos ^ 2'b11));
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge pclk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < W * H; i++)
            pxm(24'($urandom), i == 0, 1'b1, i % W, i / W, 1'b0);
    endtask

    initial begin
        logic [7:0] ta [8];
        logic [7:0] tb [8];
        logic [7:0] v;
        ta = '{8'h10, 8'h21, 8'h12, 8'h23, 8'h24, 8'h35, 8'h26, 8'h37};
        tb = '{8'h30, 8'h21, 8'h32, 8'h23, 8'h24, 8'h15, 8'h26, 8'h17};
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_rgb = '0;
        repeat (3) @(negedge pclk);
        for (int k = 0; k < 2; k++)
            chk($sformatf("u%0d_reset_state", k),
                {o_vld[k], o_raw[k], o_sof[k], o_eol[k], o_eof[k], o_err[k]}, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Reference frame with literal expectations, one idle gap mid-line.
        for (int i = 0; i < 8; i++) begin
            v = 8'(i);
            px({8'h10 + v, 8'h20 + v, 8'h30 + v}, i == 0, 1'b1, i % W, i / W, 1'b0, ta[i], tb[i]);
            if (i == 2) gap(2);
        end
        gap(4);

        // Pixels without sof while idle are dropped, then a normal frame.
        for (int i = 0; i < 3; i++) pxm(24'($urandom), 1'b0, 1'b0, i, 0, 1'b0);
        rand_frame();
        gap(4);

        // Early sof at pixel 5 restarts the frame with an error pulse.
        for (int i = 0; i < 5; i++) pxm(24'($urandom), i == 0, 1'b1, i % W, i / W, 1'b0);
        pxm(24'($urandom), 1'b1, 1'b1, 0, 0, 1'b1);
        for (int i = 1; i < W * H; i++) pxm(24'($urandom), 1'b0, 1'b1, i % W, i / W, 1'b0);
        gap(4);

        // Reset during pixel 3: pixel 2 is flushed, then sof is required again.
        pxm(24'h0a0b0c, 1'b1, 1'b1, 0, 0, 1'b0);
        pxm(24'h1a1b1c, 1'b0, 1'b1, 1, 0, 1'b0);
        pxm(24'h2a2b2c, 1'b0, 1'b0, 2, 0, 1'b0);
        @(negedge pclk);
        rst_n = 1'b0; in_valid = 1'b1; in_sof = 1'b0; in_rgb = 24'h3a3b3c;
        @(negedge pclk);
        rst_n = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_rgb = 24'h4a4b4c;
        rand_frame();
        gap(4);

        st_win = 1'b1;
        for (int i = 0; i < W * H; i++) pxm(24'h010203, i == 0, 1'b1, i % W, i / W, 1'b0);
        gap(6);
        st_win = 1'b0;
`ifdef ISP_MOSAIC_STATS_EN
        chk("stat_pulses", st_cnt, 2);
`endif
        chk("u0_queue_drained", q0.size(), 0);
        chk("u1_queue_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
